// File: rtl/led_mode_sequencer_if.sv
// Bundles the button, switch and display-control signals exchanged between
// the LED mode sequencer and its environment.
interface led_mode_sequencer_if;
  logic       btn;
  logic [1:0] SW;
  logic       tick;
  logic [1:0] mode;
  logic [1:0] color_sel;
  logic [4:0] brightness;
  logic       press;

  // The sequencer itself: consumes button/switches, produces display controls.
  modport slave (
    input  btn,
    input  SW,
    output tick,
    output mode,
    output color_sel,
    output brightness,
    output press
  );

  // The environment: drives button/switches, observes display controls.
  modport master (
    output btn,
    output SW,
    input  tick,
    input  mode,
    input  color_sel,
    input  brightness,
    input  press
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: tick generator, button synchronizer/debouncer and a
// four-mode display FSM (static, breath, blink, color-cycle) that drives the
// brightness and color-select values of the downstream PWM/color stage.
module led_mode_sequencer #(
  parameter int TICK_DIV   = 125000,
  parameter int DEB_TICKS  = 20,
  parameter int STEP_TICKS = 32,
  parameter int HOLD_TICKS = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  led_mode_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BREATH = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CYCLE  = 2'd3
  } mode_t;

  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int DEB_W    = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int STEP_MAX = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(HOLD_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);

  localparam logic [4:0] BRIGHT_MAX = 5'd31;
  localparam logic [4:0] BRIGHT_MIN = 5'd0;

  // Tick generator state
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_nxt;
  logic              r_tick;
  logic              w_tick_pre;

  // Button synchronizer / debouncer state
  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb_level;
  logic              w_deb_level_nxt;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [DEB_W-1:0]  w_deb_cnt_nxt;
  logic              w_deb_rise;
  logic              r_press;

  // Mode FSM and datapath state
  mode_t             r_mode;
  mode_t             w_mode_nxt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] w_step_cnt_nxt;
  logic [STEP_W-1:0] w_step_last;
  logic              w_step;
  logic [4:0]        r_bright;
  logic [4:0]        w_bright_nxt;
  logic              r_dir_up;
  logic              w_dir_up_nxt;
  logic [1:0]        r_color;
  logic [1:0]        w_color_nxt;

  // The tick strobe is decoded one cycle early so the registered tick and
  // anything timed off the early strobe land on the same clock edge.
  assign w_tick_pre     = (r_tick_cnt == TICK_LAST);
  assign w_tick_cnt_nxt = w_tick_pre ? TICK_ZERO : (r_tick_cnt + TICK_ONE);

  // Free-running tick divider and registered one-cycle tick pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= TICK_ZERO;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_cnt_nxt;
      r_tick     <= w_tick_pre;
    end
  end

  // Two-stage synchronizer for the asynchronous push-button; cleared stages
  // mask the button for the first two cycles after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count ticks while the synchronized button disagrees with the
  // accepted level; any agreeing cycle restarts the count.  The early tick
  // strobe is used so an accepted press coincides with the tick pulse.
  always_comb begin
    w_deb_cnt_nxt   = r_deb_cnt;
    w_deb_level_nxt = r_deb_level;
    if (r_sync2 == r_deb_level) begin
      w_deb_cnt_nxt = DEB_ZERO;
    end else if (w_tick_pre) begin
      if (r_deb_cnt == DEB_LAST) begin
        w_deb_level_nxt = r_sync2;
        w_deb_cnt_nxt   = DEB_ZERO;
      end else begin
        w_deb_cnt_nxt = r_deb_cnt + DEB_ONE;
      end
    end else begin
      w_deb_cnt_nxt = r_deb_cnt;
    end
  end

  // Only a 0->1 change of the accepted level is a press; releases are silent.
  assign w_deb_rise = w_deb_level_nxt & ~r_deb_level;

  // Debounce state and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_level <= 1'b0;
      r_deb_cnt   <= DEB_ZERO;
      r_press     <= 1'b0;
    end else begin
      r_deb_level <= w_deb_level_nxt;
      r_deb_cnt   <= w_deb_cnt_nxt;
      r_press     <= w_deb_rise;
    end
  end

  // Breath steps on its own period; blink and color-cycle share the hold period.
  assign w_step_last = (r_mode == MODE_BREATH) ? STEP_LAST : HOLD_LAST;
  assign w_step      = r_tick && (r_step_cnt == w_step_last);

  // Mode FSM next-state and datapath: a press takes priority over a
  // coincident step event and applies the entry values of the new mode.
  always_comb begin
    w_mode_nxt     = r_mode;
    w_step_cnt_nxt = r_step_cnt;
    w_bright_nxt   = r_bright;
    w_dir_up_nxt   = r_dir_up;
    w_color_nxt    = r_color;

    if (r_tick) begin
      w_step_cnt_nxt = w_step ? STEP_ZERO : (r_step_cnt + STEP_ONE);
    end else begin
      w_step_cnt_nxt = r_step_cnt;
    end

    if (r_press) begin
      w_step_cnt_nxt = STEP_ZERO;
      w_dir_up_nxt   = 1'b1;
      case (r_mode)
        MODE_STATIC: begin
          w_mode_nxt   = MODE_BREATH;
          w_bright_nxt = BRIGHT_MIN;
        end
        MODE_BREATH: begin
          w_mode_nxt   = MODE_BLINK;
          w_bright_nxt = BRIGHT_MAX;
        end
        MODE_BLINK: begin
          w_mode_nxt   = MODE_CYCLE;
          w_bright_nxt = BRIGHT_MAX;
          w_color_nxt  = bus.SW;
        end
        MODE_CYCLE: begin
          w_mode_nxt   = MODE_STATIC;
          w_bright_nxt = BRIGHT_MAX;
        end
        default: begin
          w_mode_nxt   = MODE_STATIC;
          w_bright_nxt = BRIGHT_MAX;
        end
      endcase
    end else if (w_step) begin
      case (r_mode)
        MODE_BREATH: begin
          // Reverse at the endpoints so neither 0 nor 31 is held twice.
          if (r_dir_up) begin
            if (r_bright == BRIGHT_MAX) begin
              w_bright_nxt = BRIGHT_MAX - 5'd1;
              w_dir_up_nxt = 1'b0;
            end else begin
              w_bright_nxt = r_bright + 5'd1;
            end
          end else begin
            if (r_bright == BRIGHT_MIN) begin
              w_bright_nxt = BRIGHT_MIN + 5'd1;
              w_dir_up_nxt = 1'b1;
            end else begin
              w_bright_nxt = r_bright - 5'd1;
            end
          end
        end
        MODE_BLINK: begin
          w_bright_nxt = (r_bright == BRIGHT_MIN) ? BRIGHT_MAX : BRIGHT_MIN;
        end
        MODE_CYCLE: begin
          w_color_nxt = r_color + 2'd1;
        end
        MODE_STATIC: begin
          w_bright_nxt = r_bright;
        end
        default: begin
          w_bright_nxt = r_bright;
        end
      endcase
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Mode FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= MODE_STATIC;
      r_step_cnt <= STEP_ZERO;
      r_bright   <= BRIGHT_MAX;
      r_dir_up   <= 1'b1;
      r_color    <= 2'd0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_bright   <= w_bright_nxt;
      r_dir_up   <= w_dir_up_nxt;
      r_color    <= w_color_nxt;
    end
  end

  // Color follows the switches live except in color-cycle, where it is held.
  assign bus.tick       = r_tick;
  assign bus.mode       = r_mode;
  assign bus.color_sel  = (r_mode == MODE_CYCLE) ? r_color : bus.SW;
  assign bus.brightness = r_bright;
  assign bus.press      = r_press;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed self-checking bench for led_mode_sequencer with small timing
// parameters (TICK_DIV=4, DEB_TICKS=2, STEP_TICKS=1, HOLD_TICKS=3).
module tb_led_mode_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   press_count;

  led_mode_sequencer_if bus ();

  led_mode_sequencer #(
    .TICK_DIV   (4),
    .DEB_TICKS  (2),
    .STEP_TICKS (1),
    .HOLD_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count press pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.press === 1'b1) press_count <= press_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until the tick output is seen high (bounded)
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $error("FAIL tick_timeout: observed no tick expected tick within 12 cycles");
    end
  endtask

  // Advance to the sample point just after the next step-event edge
  task automatic next_step();
    wait_tick();
    cyc();
  endtask

  // Clean release, then a held press; returns one cycle after the press pulse
  task automatic do_press();
    bit seen;
    seen = 1'b0;
    bus.btn = 1'b0;
    repeat (16) cyc();
    bus.btn = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (bus.press === 1'b1) seen = 1'b1;
    end
    check("press_seen", {31'd0, seen}, 32'd1);
    cyc();
    bus.btn = 1'b0;
  endtask

  function automatic int tri_val(input int i);
    if (i <= 31) return i;
    else if (i <= 62) return 62 - i;
    else return i - 62;
  endfunction

  initial begin
    logic [1:0] cyc_exp [4];
    logic [4:0] blink_exp [6];
    n_checks    = 0;
    n_fail      = 0;
    press_count = 0;
    bus.btn     = 1'b0;
    bus.SW      = 2'd1;
    rst         = 1'b1;
    cyc_exp     = '{2'd3, 2'd0, 2'd1, 2'd2};
    blink_exp   = '{5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd31};

    // Reset state
    repeat (3) cyc();
    check("rst_tick", {31'd0, bus.tick}, 32'd0);
    check("rst_mode", {30'd0, bus.mode}, 32'd0);
    check("rst_bright", {27'd0, bus.brightness}, 32'd31);
    check("rst_press", {31'd0, bus.press}, 32'd0);
    check("rst_color", {30'd0, bus.color_sel}, 32'd1);

    // Tick high exactly in cycles 4, 8, 12 after release
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("tick_c%0d", k), {31'd0, bus.tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Short glitch spanning only one tick: rejected
    bus.SW = 2'd2;
    wait_tick();
    bus.btn = 1'b1;
    repeat (5) cyc();
    bus.btn = 1'b0;
    repeat (12) cyc();
    check("glitch_press", press_count, 32'd0);
    check("glitch_mode", {30'd0, bus.mode}, 32'd0);

    // Long hold: one press, mode advances; release gives no pulse
    wait_tick();
    bus.btn = 1'b1;
    repeat (20) cyc();
    check("hold_press", press_count, 32'd1);
    check("hold_mode", {30'd0, bus.mode}, 32'd1);
    bus.btn = 1'b0;
    repeat (20) cyc();
    check("release_press", press_count, 32'd1);
    check("release_mode", {30'd0, bus.mode}, 32'd1);

    // BREATH -> BLINK: press coincides with a step event, entry values win
    do_press();
    check("blink_mode", {30'd0, bus.mode}, 32'd2);
    check("blink_entry", {27'd0, bus.brightness}, 32'd31);
    check("blink_color", {30'd0, bus.color_sel}, 32'd2);
    for (int t = 0; t < 6; t++) begin
      next_step();
      check($sformatf("blink_t%0d", t + 1), {27'd0, bus.brightness}, {27'd0, blink_exp[t]});
    end

    // BLINK -> CYCLE: color latched at entry, SW changes ignored
    do_press();
    check("cycle_mode", {30'd0, bus.mode}, 32'd3);
    check("cycle_bright", {27'd0, bus.brightness}, 32'd31);
    check("cycle_color0", {30'd0, bus.color_sel}, 32'd2);
    bus.SW = 2'd0;
    #1;
    check("cycle_sw_ignored", {30'd0, bus.color_sel}, 32'd2);
    for (int j = 0; j < 4; j++) begin
      repeat (3) next_step();
      check($sformatf("cycle_c%0d", j + 1), {30'd0, bus.color_sel}, {30'd0, cyc_exp[j]});
    end
    check("cycle_bright_hold", {27'd0, bus.brightness}, 32'd31);

    // CYCLE -> STATIC: fourth press wraps, color follows SW live
    do_press();
    check("wrap_mode", {30'd0, bus.mode}, 32'd0);
    check("wrap_bright", {27'd0, bus.brightness}, 32'd31);
    check("wrap_color", {30'd0, bus.color_sel}, 32'd0);
    bus.SW = 2'd1;
    #1;
    check("static_live", {30'd0, bus.color_sel}, 32'd1);

    // STATIC -> BREATH: triangle 0..31..0,1 and onward to 17
    do_press();
    check("breath_mode", {30'd0, bus.mode}, 32'd1);
    check("breath_entry", {27'd0, bus.brightness}, 32'd0);
    for (int i = 1; i <= 79; i++) begin
      next_step();
      check($sformatf("breath_s%0d", i), {27'd0, bus.brightness}, tri_val(i));
    end

    // Async reset mid-BREATH while the tick pulse is high
    wait_tick();
    check("pre_rst_tick", {31'd0, bus.tick}, 32'd1);
    check("pre_rst_bright", {27'd0, bus.brightness}, 32'd17);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bright", {27'd0, bus.brightness}, 32'd31);
    check("arst_mode", {30'd0, bus.mode}, 32'd0);
    check("arst_tick", {31'd0, bus.tick}, 32'd0);
    check("arst_press", {31'd0, bus.press}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("retick_c%0d", k), {31'd0, bus.tick}, (k == 4) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
